// File: rtl/beep_scheduler.sv
// Buzzer arbiter: sequences click, hourly chime and alarm patterns onto one registered 500 Hz tone.
// Optional macro BEEP_DEBUG_FORCE_EN adds a force_beep input that overrides the tone for bring-up.
module beep_scheduler #(
  parameter int ALARM_SEC    = 5,
  parameter int CHIME_ON_MS  = 200,
  parameter int CHIME_OFF_MS = 300,
  parameter int CLICK_MS     = 20
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       req_alarm,
  input  logic       req_chime,
  input  logic [4:0] chime_hour,
  input  logic       req_click,
  input  logic       alarm_stop,
`ifdef BEEP_DEBUG_FORCE_EN
  input  logic       force_beep,
`endif
  output logic       beep,
  output logic       busy,
  output logic [1:0] source
);

  typedef enum logic [2:0] {
    IDLE,
    CLICK,
    CHIME_ON,
    CHIME_OFF,
    ALARM
  } state_t;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_CLICK = 2'd1;
  localparam logic [1:0] SRC_CHIME = 2'd2;
  localparam logic [1:0] SRC_ALARM = 2'd3;

  localparam logic [9:0] CLICK_LAST     = 10'(CLICK_MS - 1);
  localparam logic [9:0] CHIME_ON_LAST  = 10'(CHIME_ON_MS - 1);
  localparam logic [9:0] CHIME_OFF_LAST = 10'(CHIME_OFF_MS - 1);
  localparam logic [9:0] ALARM_LAST     = 10'd999;
  localparam logic [3:0] ALARM_PERIODS  = 4'(ALARM_SEC);

  state_t     state, state_d;
  logic [9:0] ms_cnt, ms_cnt_d;
  logic [3:0] strokes, strokes_d;
  logic [3:0] secs, secs_d;
  logic       beep_d, fsm_beep, sounding, busy_d;
  logic [1:0] source_d;

  logic       chime_ok;
  logic [3:0] hour_mod;
  logic [3:0] strokes_req;

  // 12-hour stroke count: hour mod 12, with midnight/noon striking twelve.
  assign chime_ok    = req_chime && (chime_hour <= 5'd23);
  assign hour_mod    = (chime_hour >= 5'd12) ? 4'(chime_hour - 5'd12) : chime_hour[3:0];
  assign strokes_req = (hour_mod == 4'd0) ? 4'd12 : hour_mod;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state;
    ms_cnt_d  = ms_cnt + 10'd1;
    strokes_d = strokes;
    secs_d    = secs;

    case (state)
      IDLE: begin
        ms_cnt_d  = '0;
        strokes_d = '0;
        secs_d    = '0;
      end
      CLICK: begin
        if (ms_cnt == CLICK_LAST) begin
          state_d  = IDLE;
          ms_cnt_d = '0;
        end
      end
      CHIME_ON: begin
        if (ms_cnt == CHIME_ON_LAST) begin
          state_d  = CHIME_OFF;
          ms_cnt_d = '0;
        end
      end
      CHIME_OFF: begin
        if (ms_cnt == CHIME_OFF_LAST) begin
          ms_cnt_d  = '0;
          strokes_d = strokes - 4'd1;
          state_d   = (strokes <= 4'd1) ? IDLE : CHIME_ON;
          if (strokes <= 4'd1) strokes_d = '0;
        end
      end
      ALARM: begin
        if (ms_cnt == ALARM_LAST) begin
          ms_cnt_d = '0;
          secs_d   = secs + 4'd1;
          if (secs_d >= ALARM_PERIODS) begin
            state_d = IDLE;
            secs_d  = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        ms_cnt_d  = '0;
        strokes_d = '0;
        secs_d    = '0;
      end
    endcase

    // Arbitration: source doubles as the priority rank of the current owner.
    if (state == ALARM && alarm_stop) begin
      state_d   = IDLE;
      ms_cnt_d  = '0;
      secs_d    = '0;
      strokes_d = '0;
    end else if (req_alarm) begin
      state_d   = ALARM;
      ms_cnt_d  = '0;
      secs_d    = '0;
      strokes_d = '0;
    end else if (chime_ok && source < SRC_CHIME) begin
      state_d   = CHIME_ON;
      ms_cnt_d  = '0;
      strokes_d = strokes_req;
    end else if (req_click && source == SRC_NONE) begin
      state_d  = CLICK;
      ms_cnt_d = '0;
    end
  end

  always_comb begin
    source_d = SRC_NONE;
    sounding = 1'b0;
    case (state_d)
      CLICK: begin
        source_d = SRC_CLICK;
        sounding = 1'b1;
      end
      CHIME_ON: begin
        source_d = SRC_CHIME;
        sounding = 1'b1;
      end
      CHIME_OFF: source_d = SRC_CHIME;
      ALARM: begin
        source_d = SRC_ALARM;
        sounding = (ms_cnt_d < 10'd100)
                || (ms_cnt_d >= 10'd200 && ms_cnt_d < 10'd300)
                || (ms_cnt_d >= 10'd400 && ms_cnt_d < 10'd500);
      end
      default: begin
        source_d = SRC_NONE;
        sounding = 1'b0;
      end
    endcase
    busy_d   = (state_d != IDLE);
    // Every sounding burst starts on an even count, so the tone opens high.
    fsm_beep = sounding & ~ms_cnt_d[0];
  end

`ifdef BEEP_DEBUG_FORCE_EN
  assign beep_d = force_beep ? ~beep : fsm_beep;
`else
  assign beep_d = fsm_beep;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state   <= IDLE;
      ms_cnt  <= '0;
      strokes <= '0;
      secs    <= '0;
      beep    <= 1'b0;
      busy    <= 1'b0;
      source  <= SRC_NONE;
    end else begin
      state   <= state_d;
      ms_cnt  <= ms_cnt_d;
      strokes <= strokes_d;
      secs    <= secs_d;
      beep    <= beep_d;
      busy    <= busy_d;
      source  <= source_d;
    end
  end

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed bench for beep_scheduler: expected per-cycle outputs are queued with each stimulus and
// popped/compared one cycle at a time, #1 after the rising edge.
module tb_beep_scheduler;

  logic       clk_1khz   = 1'b0;
  logic       switch_clr = 1'b1;
  logic       req_alarm  = 1'b0;
  logic       req_chime  = 1'b0;
  logic       req_click  = 1'b0;
  logic       alarm_stop = 1'b0;
  logic [4:0] chime_hour = 5'd0;
  logic       beep;
  logic       busy;
  logic [1:0] source;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic       beep;
    logic       busy;
    logic [1:0] src;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  beep_scheduler dut (
    .clk_1khz  (clk_1khz),
    .switch_clr(switch_clr),
    .req_alarm (req_alarm),
    .req_chime (req_chime),
    .chime_hour(chime_hour),
    .req_click (req_click),
    .alarm_stop(alarm_stop),
    .beep      (beep),
    .busy      (busy),
    .source    (source)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic push(input string tag, input logic b, input logic bz, input logic [1:0] s);
    exp_t e;
    e.beep = b;
    e.busy = bz;
    e.src  = s;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) push(tag, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic push_click(input string tag);
    for (int i = 0; i < 20; i++) push(tag, (i % 2) == 0, 1'b1, 2'd1);
  endtask

  task automatic push_chime(input string tag, input int strokes);
    for (int s = 0; s < strokes; s++) begin
      for (int i = 0; i < 200; i++) push(tag, (i % 2) == 0, 1'b1, 2'd2);
      for (int i = 0; i < 300; i++) push(tag, 1'b0, 1'b1, 2'd2);
    end
  endtask

  function automatic logic alarm_tone(input int k);
    int m;
    m = k % 1000;
    return ((m < 100) || (m >= 200 && m < 300) || (m >= 400 && m < 500)) && ((m % 2) == 0);
  endfunction

  task automatic push_alarm(input string tag, input int first, input int last);
    for (int k = first; k < last; k++) push(tag, alarm_tone(k), 1'b1, 2'd3);
  endtask

  task automatic check_now();
    exp_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty cyc=%0d observed beep=%b busy=%b source=%0d expected an entry",
             cyc, beep, busy, source);
    end else begin
      e = exp_q.pop_front();
      assert ({beep, busy, source} === {e.beep, e.busy, e.src})
      else begin
        n_fail++;
        $error("FAIL %s cyc=%0d observed beep=%b busy=%b source=%0d expected beep=%b busy=%b source=%0d",
               e.tag, cyc, beep, busy, source, e.beep, e.busy, e.src);
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1khz);
      #1;
      req_alarm  = 1'b0;
      req_chime  = 1'b0;
      req_click  = 1'b0;
      alarm_stop = 1'b0;
      cyc++;
      check_now();
    end
  endtask

  task automatic run_all();
    int n;
    n = exp_q.size();
    step(n);
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 switch_clr = 1'b0;
    #1;
    push_idle("reset_async", 1);
    check_now();
    push_idle("reset_held", 3);
    run_all();
    switch_clr = 1'b1;
    push_idle("idle_after_reset", 3);
    run_all();

    // Key click from IDLE.
    req_click = 1'b1;
    push_click("click");
    push_idle("click_done", 3);
    run_all();

    // 15h chime, with a click and a second chime dropped mid-pattern.
    chime_hour = 5'd15;
    req_chime  = 1'b1;
    push_chime("chime15", 3);
    push_idle("chime15_done", 2);
    step(100);
    req_click = 1'b1;
    step(200);
    chime_hour = 5'd7;
    req_chime  = 1'b1;
    run_all();

    // Midnight chime strikes twelve.
    chime_hour = 5'd0;
    req_chime  = 1'b1;
    push_chime("chime0", 12);
    push_idle("chime0_done", 2);
    run_all();

    // 13h chime: a single stroke.
    chime_hour = 5'd13;
    req_chime  = 1'b1;
    push_chime("chime13", 1);
    push_idle("chime13_done", 2);
    run_all();

    // Out-of-range hour is ignored.
    chime_hour = 5'd24;
    req_chime  = 1'b1;
    push_idle("chime24", 5);
    run_all();

    // Full alarm.
    req_alarm = 1'b1;
    push_alarm("alarm_full", 0, 5000);
    push_idle("alarm_full_done", 3);
    run_all();

    // Alarm silenced at cycle 1234.
    req_alarm = 1'b1;
    push_alarm("alarm_stop_pre", 0, 1234);
    run_all();
    alarm_stop = 1'b1;
    push_idle("alarm_stop", 3);
    run_all();

    // Alarm preempts chime during its second stroke.
    chime_hour = 5'd3;
    req_chime  = 1'b1;
    push_chime("preempt_chime", 3);
    step(600);
    exp_q.delete();
    req_alarm = 1'b1;
    push_alarm("preempt_alarm", 0, 5000);
    push_idle("preempt_done", 3);
    run_all();

    // Same-cycle requests, lower-priority requests during ALARM, then alarm restart.
    chime_hour = 5'd5;
    req_click  = 1'b1;
    req_chime  = 1'b1;
    req_alarm  = 1'b1;
    push_alarm("simul_alarm", 0, 1500);
    run_all();
    req_click = 1'b1;
    req_chime = 1'b1;
    push_alarm("alarm_ignores_low", 1500, 2600);
    run_all();
    req_alarm = 1'b1;
    push_alarm("alarm_restart", 0, 5000);
    push_idle("alarm_restart_done", 3);
    run_all();

    // Reset asserted mid-alarm, then IDLE held after release.
    req_alarm = 1'b1;
    push_alarm("pre_reset_alarm", 0, 700);
    run_all();
    #1 switch_clr = 1'b0;
    #1;
    push_idle("reset_mid_alarm", 1);
    check_now();
    push_idle("reset_mid_held", 2);
    run_all();
    switch_clr = 1'b1;
    push_idle("idle_after_release", 10);
    run_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
